multiword_add_seq: RTL and testbench

- Sequencing front-end that drives the team's combinational N-bit carry-select adder to perform WORDS*N-bit addition or subtraction, one word per cycle.
- Accepts operand word pairs least-significant first over a valid/ready stream.
- Presents each word pair plus the chained carry to the adder, then registers the adder's sum into a valid/ready output stream.
- Reports final carry-out and signed overflow at the end of each operation.

---
 rtl/multiword_add_seq_if.sv | 24 ++
 rtl/multiword_add_seq.sv | 127 ++++++++++++
 tb/tb_multiword_add_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/multiword_add_seq_if.sv
// Operand and result valid/ready streams of the multi-word add/subtract sequencer.
// The master side is the producer of operands and the consumer of results.
interface multiword_add_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_last;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_last
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_last
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Drives an external N-bit adder one word per cycle to build a WORDS*N-bit add or
// subtract, chaining the carry and buffering each sum word in a single output slot.
module multiword_add_seq #(
    parameter int N     = 32,
    parameter int WORDS = 4,
    parameter int CNTW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    multiword_add_seq_if.slave   strm,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic                 add_cin,
    input  logic [N-1:0]         add_s,
    input  logic                 add_cout,
    input  logic                 add_of,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WORDS - 1);

    state_t          r_state;
    logic            r_sub;
    logic            r_carry;
    logic [CNTW-1:0] r_word_cnt;
    logic            r_out_valid;
    logic [N-1:0]    r_out_sum;
    logic            r_out_last;
    logic            r_carry_out;
    logic            r_overflow;
    logic            r_busy;
    logic            r_done;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_pop;

    // Subtraction is A + ~B with the initial carry set, so B is inverted on the way out.
    assign add_a   = strm.in_a;
    assign add_b   = r_sub ? ~strm.in_b : strm.in_b;
    assign add_cin = r_carry;

    // The output slot may be refilled in the same cycle it is popped.
    assign w_in_ready = (r_state == ST_RUN) ? (~r_out_valid | strm.out_ready) : 1'b0;
    assign w_accept   = strm.in_valid & w_in_ready;
    assign w_pop      = r_out_valid & strm.out_ready;

    assign strm.in_ready  = w_in_ready;
    assign strm.out_valid = r_out_valid;
    assign strm.out_sum   = r_out_sum;
    assign strm.out_last  = r_out_last;
    assign carry_out      = r_carry_out;
    assign overflow       = r_overflow;
    assign busy           = r_busy;
    assign done           = r_done;

    // Sequencer state, carry chain and registered result stream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sub       <= 1'b0;
            r_carry     <= 1'b0;
            r_word_cnt  <= {CNTW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_sum   <= {N{1'b0}};
            r_out_last  <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_sub      <= sub;
                        r_carry    <= sub;
                        r_word_cnt <= {CNTW{1'b0}};
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_out_sum   <= add_s;
                        r_out_valid <= 1'b1;
                        r_carry     <= add_cout;
                        r_word_cnt  <= r_word_cnt + {{(CNTW-1){1'b0}}, 1'b1};
                        if (r_word_cnt == LAST_CNT) begin
                            r_out_last  <= 1'b1;
                            r_carry_out <= add_cout;
                            r_overflow  <= add_of;
                            r_state     <= ST_DRAIN;
                        end
                    end else if (w_pop) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (w_pop) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench: directed and random multi-word operations compared against
// full-width arithmetic, with a behavioural N-bit adder attached to the sequencer.
module tb_multiword_add_seq;
    localparam int N  = 32;
    localparam int W  = 4;
    localparam int WN = N * W;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_s;
    logic         add_cout;
    logic         add_of;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;
    logic [N:0]   adder_full;

    int n_assert = 0;
    int n_fail   = 0;

    multiword_add_seq_if #(.N(N)) bus ();

    multiword_add_seq #(.N(N), .WORDS(W), .CNTW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .strm      (bus),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .add_of    (add_of),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural stand-in for the combinational carry-select adder.
    assign adder_full = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
    assign add_s      = adder_full[N-1:0];
    assign add_cout   = adder_full[N];
    assign add_of     = (add_a[N-1] == add_b[N-1]) && (adder_full[N-1] != add_a[N-1]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WN:0] obs, input logic [WN:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One full operation; rmode 0=ready high, 1=3-cycle stall on first result, 2=random.
    task automatic run_op(input logic [WN-1:0] a, input logic [WN-1:0] b, input logic s,
                          input int rmode, input int vmode, input logic poke);
        logic [WN-1:0] bb;
        logic [WN:0]   full;
        logic          exp_of;
        logic [N-1:0]  exp_word;
        int in_idx, out_idx, first_acc, first_pop, last_pop, stall_left, wi;
        bb     = s ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {{WN{1'b0}}, s};
        exp_of = (a[WN-1] == bb[WN-1]) && (full[WN-1] != a[WN-1]);
        in_idx = 0; out_idx = 0; first_acc = -1; first_pop = -1; last_pop = -1; stall_left = 3;
        @(negedge clk);
        start = 1'b1; sub = s;
        @(negedge clk);
        start = 1'b0; sub = 1'b0;
        check("busy_after_start", {{WN{1'b0}}, busy}, {{WN{1'b0}}, 1'b1});
        for (int cyc = 0; cyc < 200 && out_idx < W; cyc++) begin
            if (poke && cyc == 1) begin
                start = 1'b1; sub = ~s;
            end else begin
                start = 1'b0; sub = 1'b0;
            end
            wi = (in_idx < W) ? in_idx : 0;
            bus.in_valid = (in_idx < W) && (vmode == 0 || $urandom_range(0, 1) == 1);
            bus.in_a     = a[wi*N +: N];
            bus.in_b     = b[wi*N +: N];
            if (rmode == 0)      bus.out_ready = 1'b1;
            else if (rmode == 1) bus.out_ready = (stall_left == 0) || !bus.out_valid;
            else                 bus.out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (bus.out_valid) begin
                exp_word = full[out_idx*N +: N];
                check("out_sum", {{(WN+1-N){1'b0}}, bus.out_sum}, {{(WN+1-N){1'b0}}, exp_word});
                check("out_last", {{WN{1'b0}}, bus.out_last}, {{WN{1'b0}}, (out_idx == W - 1)});
                if (!bus.out_ready) begin
                    check("bp_in_ready", {{WN{1'b0}}, bus.in_ready}, {(WN+1){1'b0}});
                    if (stall_left > 0) stall_left--;
                end
            end
            check("done_early", {{WN{1'b0}}, done}, {(WN+1){1'b0}});
            if (bus.in_valid && bus.in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                in_idx++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (first_pop < 0) first_pop = cyc;
                if (out_idx == W - 1) begin
                    check("carry_out", {{WN{1'b0}}, carry_out}, {{WN{1'b0}}, full[WN]});
                    check("overflow", {{WN{1'b0}}, overflow}, {{WN{1'b0}}, exp_of});
                end
                last_pop = cyc;
                out_idx++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        check("words_out", WN'(out_idx), WN'(W));
        check("words_in", WN'(in_idx), WN'(W));
        #1;
        check("done_pulse", {{WN{1'b0}}, done}, {{WN{1'b0}}, 1'b1});
        check("busy_end", {{WN{1'b0}}, busy}, {(WN+1){1'b0}});
        check("out_valid_end", {{WN{1'b0}}, bus.out_valid}, {(WN+1){1'b0}});
        check("carry_hold", {{WN{1'b0}}, carry_out}, {{WN{1'b0}}, full[WN]});
        if (rmode == 0 && vmode == 0) begin
            check("first_latency", WN'(first_pop - first_acc), WN'(1));
            check("throughput", WN'(last_pop - first_pop), WN'(W - 1));
        end
        @(negedge clk);
        #1;
        check("done_one_cycle", {{WN{1'b0}}, done}, {(WN+1){1'b0}});
    endtask

    initial begin : stim
        logic [WN-1:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {{WN{1'b0}}, bus.out_valid}, {(WN+1){1'b0}});
        check("rst_out_sum", {{(WN+1-N){1'b0}}, bus.out_sum}, {(WN+1){1'b0}});
        check("rst_flags", {{(WN-4){1'b0}}, bus.out_last, carry_out, overflow, busy, done},
              {(WN+1){1'b0}});
        check("rst_in_ready", {{WN{1'b0}}, bus.in_ready}, {(WN+1){1'b0}});
        rst_n = 1'b1;

        // Carry chain, borrow chain and signed overflow cases.
        run_op({32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}, {32'h0, 32'h0, 32'h0, 32'h1}, 1'b0, 0, 0, 1'b0);
        run_op({WN{1'b0}}, {32'h0, 32'h0, 32'h0, 32'h1}, 1'b1, 0, 0, 1'b0);
        run_op({32'h7FFFFFFF, 32'h0, 32'h0, 32'h0}, {32'h00000001, 32'h0, 32'h0, 32'h0}, 1'b0, 0, 0, 1'b0);
        run_op({32'h80000000, 32'h0, 32'h0, 32'h0}, {32'h80000000, 32'h0, 32'h0, 32'h0}, 1'b0, 0, 0, 1'b0);

        // Backpressure on the first result word.
        run_op({32'h12345678, 32'h9ABCDEF0, 32'hFFFFFFFF, 32'h80000000},
               {32'h0F0F0F0F, 32'h11111111, 32'h00000001, 32'h80000000}, 1'b0, 1, 0, 1'b0);

        // start during RUN with the opposite sub value must be ignored.
        run_op({32'h0, 32'h0, 32'h0, 32'h00000010}, {32'h0, 32'h0, 32'h0, 32'h00000020}, 1'b1, 0, 0, 1'b1);

        // Abort after two accepted words.
        @(negedge clk);
        start = 1'b1; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b1; bus.in_a = 32'hFFFFFFFF; bus.in_b = 32'h1; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        #1;
        check("abort_out_valid", {{WN{1'b0}}, bus.out_valid}, {(WN+1){1'b0}});
        check("abort_busy", {{WN{1'b0}}, busy}, {(WN+1){1'b0}});
        for (int k = 0; k < 3; k++) begin
            check("abort_no_done", {{WN{1'b0}}, done}, {(WN+1){1'b0}});
            @(negedge clk);
            #1;
        end
        run_op({32'h0, 32'h0, 32'h0, 32'h5}, {32'h0, 32'h0, 32'h0, 32'h3}, 1'b1, 0, 0, 1'b0);

        // Random operands, random handshakes on both streams.
        for (int t = 0; t < 8; t++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (t[1:0] == 2'd1) rb = ~ra;
            run_op(ra, rb, $urandom_range(0, 1) == 1, 2, 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
